// File: rtl/ifm_window_addr_gen_pkg.sv
// Shared definitions for the IFM/OFM/weight address generators.
// Contents:
//   gen_state_e - generator FSM encoding (IDLE / GEN)
//   ofm_size()  - output feature-map edge length for a given IFM, kernel and stride
//   cnt_width() - register width needed to hold 0..max_val (never below 1)
package ifm_addr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } gen_state_e;

  function automatic int ofm_size(input int ifm_size, input int kernel_size, input int stride);
    return (ifm_size - kernel_size) / stride + 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ifm_window_addr_gen_if.sv
// Address-stream bundle between the window address generator and its consumer.
// Signals:
//   start, clear, addr_ready              - control/flow inputs to the generator
//   ifm_addr, addr_valid, window_last,
//   frame_last, busy, done                - generator outputs
// Modports: master = generator side, slave = consumer/controller side.
interface ifm_window_addr_gen_if #(
  parameter int ADDR_WIDTH = 19
);

  logic                  start;
  logic                  clear;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] ifm_addr;
  logic                  addr_valid;
  logic                  window_last;
  logic                  frame_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, clear, addr_ready,
    output ifm_addr, addr_valid, window_last, frame_last, busy, done
  );

  modport slave (
    output start, clear, addr_ready,
    input  ifm_addr, addr_valid, window_last, frame_last, busy, done
  );

endinterface

// File: rtl/ifm_window_addr_gen_wrap_counter.sv
// Modulo counter 0..MAX used for every loop index of the generator.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous return to zero (wins over inc)
//   inc        - advance by one; MAX wraps to 0
//   at_max     - counter sits at MAX, so the next inc wraps
module wrap_counter
  import ifm_addr_pkg::*;
#(
  parameter int MAX   = 1,
  parameter int WIDTH = cnt_width(MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Terminal-count flag
  always_comb begin
    at_max = (count_r == MAX_V);
  end

  // Count register: clear first, then wrap-or-increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO_V;
    end else if (clear) begin
      count_r <= ZERO_V;
    end else if (inc) begin
      count_r <= at_max ? ZERO_V : (count_r + ONE_V);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ifm_window_addr_gen.sv
// IFM window address generator: on each start, streams the IFM word addresses
// of one KERNEL_SIZE x KERNEL_SIZE x IFM_CHANNEL window (c outer, r, k inner),
// then advances the window position (ox, then oy) with frame wrap-around.
// Addresses are built purely by adds/reloads of base registers.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - master side of ifm_window_addr_gen_if (start/clear/addr_ready in,
//                ifm_addr/addr_valid/window_last/frame_last/busy/done out)
module ifm_window_addr_gen
  import ifm_addr_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int IFM_SIZE    = 416,
  parameter int IFM_CHANNEL = 3,
  parameter int ADDR_WIDTH  = 19
) (
  input logic                  clk,
  input logic                  rst_n,
  ifm_window_addr_gen_if.master bus
);

  localparam int OFM_SIZE = ofm_size(IFM_SIZE, KERNEL_SIZE, STRIDE);

  localparam logic [ADDR_WIDTH-1:0] ZERO_A    = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_STEP  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(IFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] CH_STEP   = ADDR_WIDTH'(IFM_SIZE * IFM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] COL_STEP  = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(STRIDE * IFM_SIZE);

  gen_state_e state_r;
  gen_state_e state_nxt_s;

  // Base registers: line = window row start (oy), win = window origin (oy, ox),
  // chan = origin of current channel plane, row = start of current kernel row.
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] row_base_r;
  logic [ADDR_WIDTH-1:0] chan_base_r;
  logic [ADDR_WIDTH-1:0] win_base_r;
  logic [ADDR_WIDTH-1:0] line_base_r;
  logic                  done_r;

  logic k_max_s, r_max_s, c_max_s, ox_max_s, oy_max_s;
  logic gen_s, hs_s, last_s, start_acc_s;

  // Control decode; clear masks both the handshake and start
  always_comb begin
    gen_s       = (state_r == ST_GEN);
    hs_s        = gen_s && bus.addr_ready && !bus.clear;
    last_s      = k_max_s && r_max_s && c_max_s;
    start_acc_s = !gen_s && bus.start && !bus.clear;
  end

  wrap_counter #(.MAX(KERNEL_SIZE - 1)) u_k_cnt (
    .clk(clk), .rst_n(rst_n), .clear(bus.clear),
    .inc(hs_s), .at_max(k_max_s)
  );

  wrap_counter #(.MAX(KERNEL_SIZE - 1)) u_r_cnt (
    .clk(clk), .rst_n(rst_n), .clear(bus.clear),
    .inc(hs_s && k_max_s), .at_max(r_max_s)
  );

  wrap_counter #(.MAX(IFM_CHANNEL - 1)) u_c_cnt (
    .clk(clk), .rst_n(rst_n), .clear(bus.clear),
    .inc(hs_s && k_max_s && r_max_s), .at_max(c_max_s)
  );

  wrap_counter #(.MAX(OFM_SIZE - 1)) u_ox_cnt (
    .clk(clk), .rst_n(rst_n), .clear(bus.clear),
    .inc(hs_s && last_s), .at_max(ox_max_s)
  );

  wrap_counter #(.MAX(OFM_SIZE - 1)) u_oy_cnt (
    .clk(clk), .rst_n(rst_n), .clear(bus.clear),
    .inc(hs_s && last_s && ox_max_s), .at_max(oy_max_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) begin
          state_nxt_s = ST_GEN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (bus.clear) begin
          state_nxt_s = ST_IDLE;
        end else if (hs_s && last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GEN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; all are functions of registered state only
  always_comb begin
    bus.addr_valid  = gen_s;
    bus.busy        = gen_s;
    bus.ifm_addr    = addr_r;
    bus.window_last = gen_s && last_s;
    bus.frame_last  = gen_s && ox_max_s && oy_max_s;
    bus.done        = done_r;
  end

  // One-cycle completion pulse after the last handshake of a window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= hs_s && last_s;
    end
  end

  // Address datapath: the innermost loop whose index is not at max decides
  // which base register advances; the window-end step moves the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= ZERO_A;
      row_base_r  <= ZERO_A;
      chan_base_r <= ZERO_A;
      win_base_r  <= ZERO_A;
      line_base_r <= ZERO_A;
    end else if (bus.clear) begin
      addr_r      <= ZERO_A;
      row_base_r  <= ZERO_A;
      chan_base_r <= ZERO_A;
      win_base_r  <= ZERO_A;
      line_base_r <= ZERO_A;
    end else if (start_acc_s) begin
      addr_r      <= win_base_r;
      row_base_r  <= win_base_r;
      chan_base_r <= win_base_r;
    end else if (hs_s) begin
      if (!k_max_s) begin
        addr_r <= addr_r + ONE_STEP;
      end else if (!r_max_s) begin
        row_base_r <= row_base_r + ROW_STEP;
        addr_r     <= row_base_r + ROW_STEP;
      end else if (!c_max_s) begin
        chan_base_r <= chan_base_r + CH_STEP;
        row_base_r  <= chan_base_r + CH_STEP;
        addr_r      <= chan_base_r + CH_STEP;
      end else if (!ox_max_s) begin
        win_base_r <= win_base_r + COL_STEP;
      end else if (!oy_max_s) begin
        line_base_r <= line_base_r + LINE_STEP;
        win_base_r  <= line_base_r + LINE_STEP;
      end else begin
        line_base_r <= ZERO_A;
        win_base_r  <= ZERO_A;
      end
    end else begin
      addr_r <= addr_r;
    end
  end

endmodule

// File: doc/ifm_window_addr_gen.md
IFM_WINDOW_ADDR_GEN -- requirements
Module: ifm_window_addr_gen

Interface
REQ-001 Parameter KERNEL_SIZE, default 3, kernel width and height in pixels (>=1).
REQ-002 Parameter STRIDE, default 1, window step in pixels, applied both horizontally and vertically (>=1).
REQ-003 Parameter IFM_SIZE, default 416, square IFM width and height in pixels.
REQ-004 Parameter IFM_CHANNEL, default 3, number of input channels.
REQ-005 Parameter ADDR_WIDTH, default 19, address width; SHALL satisfy 2^ADDR_WIDTH >= IFM_CHANNEL*IFM_SIZE^2.
REQ-006 Derived constant OFM_SIZE SHALL equal (IFM_SIZE-KERNEL_SIZE)/STRIDE+1, integer division.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  request one window; sampled only in IDLE.
REQ-010 clear  in  1  synchronous abort; zeroes frame position.
REQ-011 addr_ready  in  1  consumer accepts ifm_addr this cycle.
REQ-012 ifm_addr  out  ADDR_WIDTH  current IFM word address.
REQ-013 addr_valid  out  1  ifm_addr is valid.
REQ-014 window_last  out  1  ifm_addr is the final address of the window.
REQ-015 frame_last  out  1  current window is the final window of the frame (oy=ox=OFM_SIZE-1).
REQ-016 busy  out  1  window generation in progress.
REQ-017 done  out  1  one-cycle pulse after the last handshake of a window.

Function
REQ-018 States SHALL be IDLE and GEN only.
REQ-019 IDLE->GEN on start=1 and clear=0; addr_valid=1 with the first address in the next cycle.
REQ-020 Address SHALL be c*IFM_SIZE^2 + (oy*STRIDE+r)*IFM_SIZE + ox*STRIDE + k.
REQ-021 Loop order SHALL be: c outermost (0..IFM_CHANNEL-1), then r (0..KERNEL_SIZE-1), then k innermost (0..KERNEL_SIZE-1).
REQ-022 One window SHALL consist of exactly IFM_CHANNEL*KERNEL_SIZE^2 addresses.
REQ-023 Address arithmetic SHALL be incremental only (add/reload of row base and channel base registers); no multiplier in the per-address path.
REQ-024 A handshake occurs when addr_valid and addr_ready are both 1; the generator advances exactly one address per handshake.
REQ-025 While addr_valid=1 and addr_ready=0, ifm_addr, window_last and frame_last SHALL hold stable.
REQ-026 Full throughput: with addr_ready held at 1, a new address is presented every cycle.
REQ-027 On the window_last handshake, the next cycle SHALL have state=IDLE, addr_valid=0, busy=0 and done=1.
REQ-028 A start in the done cycle SHALL be accepted, giving a one-cycle bubble between windows.
REQ-029 After each window, ox SHALL increment; at ox=OFM_SIZE-1 it wraps to 0 and oy increments.
REQ-030 After the frame_last window, ox and oy SHALL wrap to 0 (frame wrap-around).
REQ-031 start in GEN SHALL be ignored.
REQ-032 clear SHALL have priority over start and over a handshake in the same cycle.
REQ-033 clear SHALL cause next cycle: IDLE, addr_valid=0, ox=oy=0, done=0.

Reset
REQ-034 rst_n low at any time, including mid-window, SHALL force: IDLE; ifm_addr=0; addr_valid, window_last, frame_last, busy, done = 0; all counters and bases = 0.
REQ-035 The first start after reset SHALL generate the window at ox=oy=0.

Structure
REQ-036 State encodings and the OFM_SIZE derivation SHALL reside in shared package ifm_addr_pkg, reused by the OFM/weight address generators.
REQ-037 A single sub-module wrap_counter (parametrised max, inc, wrap flag) SHALL be instantiated for k, r, c, ox and oy.

Verification (K=3, S=2, IFM_SIZE=7, CH=2 unless noted)
REQ-038 Reset, start, ready=1 -> 18 addresses, one per cycle: 0,1,2,7,8,9,14,15,16,49,50,51,56,57,58,63,64,65; window_last on 65; done the next cycle.
REQ-039 Second start -> first address 2, last address 67; third start -> first 4; fourth start -> first 14.
REQ-040 Ninth window -> frame_last=1 for the whole window, last address 97; tenth start -> first address 0.
REQ-041 ready toggled pseudo-randomly -> same address sequence as REQ-038, stable during stalls, no address dropped or repeated.
REQ-042 clear or rst_n asserted at the 5th address -> addr_valid=0 next cycle; next start -> first address 0.
REQ-043 Defaults (K=3, S=1, 416, CH=3) -> first window last address 2*173056 + 2*416 + 2 = 346946; OFM_SIZE=414.
